// File: rtl/clk_gen_frac_pkg.sv
// Shared types and helpers for the multi-channel fractional clock generator.
package clk_gen_frac_pkg;

  // Internal datapath width. Channel configs are zero-extended to this, so
  // the top-level C_W parameter must not exceed it.
  localparam int unsigned C_W_DEF = 32;

  // Per-channel configuration: num = system frequency, den = target frequency.
  typedef struct packed {
    logic [C_W_DEF-1:0] num;
    logic [C_W_DEF-1:0] den;
  } ch_cfg_t;

  // A config is usable only if both terms are non-zero and the output does
  // not exceed fsys/2, i.e. 2*den <= num.
  function automatic logic cfg_valid(input logic [C_W_DEF-1:0] num,
                                     input logic [C_W_DEF-1:0] den);
    logic [C_W_DEF:0] den2;
    den2 = {den, 1'b0};
    return (num != '0) && (den != '0) && (den2 <= {1'b0, num});
  endfunction

endpackage

// File: rtl/clk_gen_frac_ch.sv
// One fractional-divider channel: config registers, phase accumulator,
// output toggle flop, rising-edge enable pulse and config-error flag.
module clk_gen_frac_ch
  import clk_gen_frac_pkg::*;
#(
  parameter int unsigned C_W = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic [C_W-1:0] num_i,
  input  logic [C_W-1:0] den_i,
  input  logic           stop_i,
  output logic           clk_o,
  output logic           en_o,
  output logic           err_o
);

  // Two extra bits: acc < num < 2^W and 2*den < 2^(W+1), so the sum never wraps.
  localparam int unsigned SumW = C_W_DEF + 2;

  ch_cfg_t              cfg_q, cfg_d, cfg_new;
  logic [C_W_DEF-1:0]   acc_q, acc_d;
  logic                 clk_q, clk_d;
  logic                 en_q, en_d;
  logic                 err_q, err_d;
  logic                 act_q, act_d;
  logic [SumW-1:0]      sum;
  logic [SumW-1:0]      num_ext;
  logic                 new_valid;

  // Next-state: a load restarts the channel; otherwise an active, unstopped
  // channel advances its accumulator by 2*den and toggles on wrap past num.
  always_comb begin
    cfg_new.num = C_W_DEF'(num_i);
    cfg_new.den = C_W_DEF'(den_i);
    new_valid   = cfg_valid(cfg_new.num, cfg_new.den);
    num_ext     = {2'b00, cfg_q.num};
    sum         = {2'b00, acc_q} + {1'b0, cfg_q.den, 1'b0};

    cfg_d = cfg_q;
    acc_d = acc_q;
    clk_d = clk_q;
    en_d  = 1'b0;
    err_d = err_q;
    act_d = act_q;

    if (load_i) begin
      cfg_d = cfg_new;
      acc_d = '0;
      clk_d = 1'b0;
      err_d = ~new_valid;
      act_d = new_valid;
    end else if (act_q && !stop_i) begin
      if (sum >= num_ext) begin
        acc_d = C_W_DEF'(sum - num_ext);
        clk_d = ~clk_q;
        en_d  = ~clk_q;
      end else begin
        acc_d = sum[C_W_DEF-1:0];
      end
    end
  end

  // State registers with synchronous reset to an idle, unconfigured channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q <= '0;
      acc_q <= '0;
      clk_q <= 1'b0;
      en_q  <= 1'b0;
      err_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      acc_q <= acc_d;
      clk_q <= clk_d;
      en_q  <= en_d;
      err_q <= err_d;
      act_q <= act_d;
    end
  end

  assign clk_o = clk_q;
  assign en_o  = en_q;
  assign err_o = err_q;

endmodule

// File: rtl/clk_gen_frac_mc.sv
// Multi-channel fractional clock generator: C_CH independent channels, each
// producing fsys*den/num with a registered clock and a rising-edge enable.
module clk_gen_frac_mc
  import clk_gen_frac_pkg::*;
#(
  parameter int unsigned C_CH  = 4,
  parameter int unsigned C_W   = 32,
  parameter int unsigned C_CHW = (C_CH > 1) ? $clog2(C_CH) : 1
) (
  input  logic             I_sys_clk,
  input  logic             I_rst,
  input  logic             I_cfg_wr,
  input  logic [C_CHW-1:0] I_cfg_ch,
  input  logic [C_W-1:0]   I_cfg_num,
  input  logic [C_W-1:0]   I_cfg_den,
  input  logic [C_CH-1:0]  I_gen_stop,
  output logic [C_CH-1:0]  O_div_exp_clk,
  output logic [C_CH-1:0]  O_clk_en,
  output logic [C_CH-1:0]  O_cfg_err
);

  logic [C_CH-1:0] load;

  for (genvar g = 0; g < C_CH; g++) begin : g_ch
    // Writes to an index with no matching channel decode to nothing.
    assign load[g] = I_cfg_wr && (I_cfg_ch == C_CHW'(g));

    clk_gen_frac_ch #(
      .C_W (C_W)
    ) u_ch (
      .clk_i  (I_sys_clk),
      .rst_i  (I_rst),
      .load_i (load[g]),
      .num_i  (I_cfg_num),
      .den_i  (I_cfg_den),
      .stop_i (I_gen_stop[g]),
      .clk_o  (O_div_exp_clk[g]),
      .en_o   (O_clk_en[g]),
      .err_o  (O_cfg_err[g])
    );
  end

endmodule

// File: tb/tb_clk_gen_frac_mc.sv
// Self-checking bench for clk_gen_frac_mc: directed config sequences with
// hand-computed checkpoints plus a per-cycle ideal-phase reference.
module tb_clk_gen_frac_mc;

  localparam int C_CH  = 4;
  localparam int C_W   = 32;
  localparam int C_CHW = 2;

  logic             I_sys_clk = 1'b0;
  logic             I_rst;
  logic             I_cfg_wr;
  logic [C_CHW-1:0] I_cfg_ch;
  logic [C_W-1:0]   I_cfg_num;
  logic [C_W-1:0]   I_cfg_den;
  logic [C_CH-1:0]  I_gen_stop;
  logic [C_CH-1:0]  O_div_exp_clk;
  logic [C_CH-1:0]  O_clk_en;
  logic [C_CH-1:0]  O_cfg_err;

  always #5 I_sys_clk = ~I_sys_clk;

  clk_gen_frac_mc #(
    .C_CH  (C_CH),
    .C_W   (C_W),
    .C_CHW (C_CHW)
  ) u_dut (
    .I_sys_clk     (I_sys_clk),
    .I_rst         (I_rst),
    .I_cfg_wr      (I_cfg_wr),
    .I_cfg_ch      (I_cfg_ch),
    .I_cfg_num     (I_cfg_num),
    .I_cfg_den     (I_cfg_den),
    .I_gen_stop    (I_gen_stop),
    .O_div_exp_clk (O_div_exp_clk),
    .O_clk_en      (O_clk_en),
    .O_cfg_err     (O_cfg_err)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Reference state: number of running edges since config, per channel.
  longint ph_m  [C_CH];
  longint num_m [C_CH];
  longint den_m [C_CH];
  bit     act_m [C_CH];
  bit     err_m [C_CH];
  int     en_cnt[C_CH];

  // Half-period tracking on channel 2.
  bit     hp_on;
  bit     hp_prev;
  longint hp_last, hp_min, hp_max;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Ideal output level after k running edges: parity of floor(2*den*k/num).
  function automatic bit lvl(input longint k, input longint num, input longint den);
    if (k <= 0) return 1'b0;
    return bit'(((k * 2 * den) / num) % 2);
  endfunction

  // One clock: capture driven inputs, advance the reference, compare all channels.
  task automatic step();
    logic            rst_s  = I_rst;
    logic            wr_s   = I_cfg_wr;
    logic [C_CHW-1:0] ch_s  = I_cfg_ch;
    longint          num_s  = longint'(I_cfg_num);
    longint          den_s  = longint'(I_cfg_den);
    logic [C_CH-1:0] stop_s = I_gen_stop;
    logic [C_CH-1:0] exp_clk, exp_en, exp_err;
    bit              adv;
    @(posedge I_sys_clk);
    #1;
    cyc++;
    for (int c = 0; c < C_CH; c++) begin
      adv = 1'b0;
      if (rst_s) begin
        act_m[c] = 1'b0;
        err_m[c] = 1'b0;
        ph_m[c]  = 0;
      end else if (wr_s && int'(ch_s) == c) begin
        num_m[c] = num_s;
        den_m[c] = den_s;
        err_m[c] = (den_s == 0) || (num_s == 0) || (2 * den_s > num_s);
        act_m[c] = !err_m[c];
        ph_m[c]  = 0;
      end else if (act_m[c] && !stop_s[c]) begin
        ph_m[c]++;
        adv = 1'b1;
      end
      exp_clk[c] = act_m[c] && lvl(ph_m[c], num_m[c], den_m[c]);
      exp_en[c]  = adv && lvl(ph_m[c], num_m[c], den_m[c]) &&
                   !lvl(ph_m[c] - 1, num_m[c], den_m[c]);
      exp_err[c] = err_m[c];
      en_cnt[c] += int'(O_clk_en[c]);
    end
    check_val("clk_vec", 64'(O_div_exp_clk), 64'(exp_clk));
    check_val("en_vec",  64'(O_clk_en),      64'(exp_en));
    check_val("err_vec", 64'(O_cfg_err),     64'(exp_err));
    if (hp_on && (O_div_exp_clk[2] != hp_prev)) begin
      if (cyc - hp_last < hp_min) hp_min = cyc - hp_last;
      if (cyc - hp_last > hp_max) hp_max = cyc - hp_last;
      hp_last = cyc;
    end
    hp_prev = O_div_exp_clk[2];
  endtask

  task automatic cfg(input int ch, input longint num, input longint den);
    I_cfg_wr  = 1'b1;
    I_cfg_ch  = C_CHW'(ch);
    I_cfg_num = C_W'(num);
    I_cfg_den = C_W'(den);
    step();
    I_cfg_wr  = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < C_CH; c++) begin
      ph_m[c] = 0; num_m[c] = 0; den_m[c] = 0;
      act_m[c] = 1'b0; err_m[c] = 1'b0; en_cnt[c] = 0;
    end
    hp_on = 1'b0; hp_prev = 1'b0; hp_last = 0; hp_min = 0; hp_max = 0;
    I_rst = 1'b1; I_cfg_wr = 1'b0; I_cfg_ch = '0;
    I_cfg_num = '0; I_cfg_den = '0; I_gen_stop = '0;

    // Reset state.
    step();
    step();
    check_val("rst_clk", 64'(O_div_exp_clk), 64'h0);
    check_val("rst_en",  64'(O_clk_en),      64'h0);
    check_val("rst_err", 64'(O_cfg_err),     64'h0);
    I_rst = 1'b0;

    // ch0 10/1: first toggle 5 edges after config, period 10.
    cfg(0, 10, 1);
    en_cnt[0] = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 4) check_val("ch0_pre_toggle", 64'(O_div_exp_clk[0]), 64'h0);
      if (k == 5) check_val("ch0_first_toggle", 64'(O_div_exp_clk[0]), 64'h1);
      if (k == 10) check_val("ch0_first_fall", 64'(O_div_exp_clk[0]), 64'h0);
    end
    check_val("ch0_en_cnt", 64'(en_cnt[0]), 64'd4);

    // ch1 3/1: toggles at 2,3,5,6,...; 1000 rising edges in 3000 cycles.
    cfg(1, 3, 1);
    en_cnt[1] = 0;
    for (int k = 1; k <= 3000; k++) begin
      step();
      if (k == 2) check_val("ch1_k2", 64'(O_div_exp_clk[1]), 64'h1);
      if (k == 3) check_val("ch1_k3", 64'(O_div_exp_clk[1]), 64'h0);
      if (k == 4) check_val("ch1_k4", 64'(O_div_exp_clk[1]), 64'h0);
    end
    check_val("ch1_en_cnt", 64'(en_cnt[1]), 64'd1000);

    // ch2 125000/2048: 15625 cycles is exactly 512 toggles = 256 pulses.
    cfg(2, 125000, 2048);
    en_cnt[2] = 0;
    hp_on = 1'b1; hp_last = cyc; hp_min = 1000; hp_max = 0;
    repeat (15625) step();
    hp_on = 1'b0;
    check_val("ch2_en_cnt", 64'(en_cnt[2]), 64'd256);
    check_val("ch2_hp_min", 64'(hp_min), 64'd30);
    check_val("ch2_hp_max", 64'(hp_max), 64'd31);

    // ch3 config errors, then a valid fsys/2 setting.
    cfg(3, 10, 0);
    check_val("ch3_err_den0", 64'(O_cfg_err[3]), 64'h1);
    repeat (10) step();
    check_val("ch3_idle", 64'(O_div_exp_clk[3]), 64'h0);
    cfg(3, 4, 3);
    check_val("ch3_err_fast", 64'(O_cfg_err[3]), 64'h1);
    cfg(3, 4, 2);
    check_val("ch3_err_clear", 64'(O_cfg_err[3]), 64'h0);
    step();
    check_val("ch3_hi", 64'(O_div_exp_clk[3]), 64'h1);
    step();
    check_val("ch3_lo", 64'(O_div_exp_clk[3]), 64'h0);

    // Stop ch0 for 7 edges mid-high phase; resume shifted by 7.
    cfg(0, 10, 1);
    repeat (6) step();
    check_val("ch0_high_before_stop", 64'(O_div_exp_clk[0]), 64'h1);
    en_cnt[0] = 0;
    I_gen_stop[0] = 1'b1;
    repeat (7) step();
    check_val("ch0_stop_en_cnt", 64'(en_cnt[0]), 64'd0);
    check_val("ch0_frozen", 64'(O_div_exp_clk[0]), 64'h1);
    I_gen_stop[0] = 1'b0;
    repeat (3) step();
    check_val("ch0_resume_hi", 64'(O_div_exp_clk[0]), 64'h1);
    step();
    check_val("ch0_resume_fall", 64'(O_div_exp_clk[0]), 64'h0);
    repeat (26) step();

    // Write with stop held: restart wins, channel stays frozen at 0.
    I_gen_stop[0] = 1'b1;
    cfg(0, 10, 1);
    repeat (8) step();
    check_val("ch0_stop_restart", 64'(O_div_exp_clk[0]), 64'h0);
    I_gen_stop[0] = 1'b0;
    repeat (12) step();

    // Rewrite ch0 mid-high while others run.
    cfg(0, 10, 1);
    repeat (7) step();
    check_val("ch0_mid_high", 64'(O_div_exp_clk[0]), 64'h1);
    cfg(0, 20, 1);
    check_val("ch0_restart_low", 64'(O_div_exp_clk[0]), 64'h0);
    repeat (30) step();

    // Reset mid-run.
    I_rst = 1'b1;
    step();
    check_val("mid_rst_clk", 64'(O_div_exp_clk), 64'h0);
    check_val("mid_rst_err", 64'(O_cfg_err), 64'h0);
    I_rst = 1'b0;
    repeat (5) step();
    check_val("post_rst_idle", 64'(O_div_exp_clk), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_gen_frac_mc.md
Name: clk_gen_frac_mc

Overview:
- Synthesizable, multi-channel fractional clock generator. Derives C_CH independent low-jitter output clocks from one system clock, each at ratio I_cfg_den/I_cfg_num of the system frequency, e.g. 2.048 MHz from 125 MHz.
- Sits in the shared clock/reset infrastructure. Serves both benches and RTL that need E1/T1/PCM-rate clocks or clock enables.
- Successor to the single-channel fixed-config generator. Adds per-channel runtime config, a clock-enable pulse output, per-channel stop and a config-error flag.

Parameters:
- C_CH, 4: number of independent output channels (1..16).
- C_W, 32: width of the numerator (system freq) and denominator (expected freq) fields.
- C_CHW, $clog2(C_CH) (min 1): channel index width.

Ports:
- I_sys_clk  in  1  system clock; all logic is on the rising edge.
- I_rst  in  1  synchronous reset, active-high.
- I_cfg_wr  in  1  config write strobe, one cycle.
- I_cfg_ch  in  C_CHW  target channel of the write.
- I_cfg_num  in  C_W  numerator: system clock frequency in any unit.
- I_cfg_den  in  C_W  denominator: desired output frequency in the same unit.
- I_gen_stop  in  C_CH  per-channel freeze, level.
- O_div_exp_clk  out  C_CH  generated clocks, registered.
- O_clk_en  out  C_CH  one-cycle pulse coincident with each 0->1 of O_div_exp_clk.
- O_cfg_err  out  C_CH  channel config invalid; channel held idle.

Behaviour:
- Reset (I_rst=1 at an edge): for every channel num=0, den=0, acc=0, O_div_exp_clk=0, O_clk_en=0, O_cfg_err=0, channel idle. Reset takes priority over everything.
- Idle channel (never configured, or cfg_err=1): outputs held 0, acc held 0.
- Config write, I_cfg_wr=1 at edge T. Takes effect at T+1 for channel I_cfg_ch:
  - num and den latched, acc=0, O_div_exp_clk=0, O_clk_en=0.
  - O_cfg_err set if den==0, num==0, or 2*den>num (output would exceed fsys/2). Otherwise cleared.
  - A write mid-operation restarts the channel immediately. The partial phase is truncated.
  - A write with I_cfg_ch>=C_CH is ignored.
- Running channel, each edge with I_gen_stop[ch]=0:
  - sum = acc + 2*den, computed in C_W+2 bits with no overflow.
  - If sum>=num: acc<=sum-num and O_div_exp_clk toggles. O_clk_en<=1 iff the new level is 1.
  - Else: acc<=sum, O_clk_en<=0.
- Invariant: acc<num at all times.
- Long-run average output frequency is exactly fsys*den/num. Instantaneous half-period is floor or ceil of num/(2*den) cycles.
- First toggle: ceil(num/(2*den)) cycles after the config edge.
- I_gen_stop[ch]=1: acc and O_div_exp_clk frozen at their current values, O_clk_en=0. Resuming continues phase-exactly from the frozen acc.
- Simultaneous I_gen_stop and config write to the same channel: the write wins (restart). The channel then stays frozen at 0 while stop is high.
- Channels are fully independent. A write to one channel never disturbs another.
- All outputs come straight from flops. Use O_div_exp_clk via a clock buffer in RTL, or O_clk_en directly as an enable.

Decomposition:
- Package clk_gen_frac_pkg:
  - C_W_DEF.
  - typedef struct ch_cfg_t {num, den}.
  - Function cfg_valid(num, den).
- Sub-module clk_gen_frac_ch: one channel (cfg regs, accumulator, toggle flop, en pulse, err flag). The top generates C_CH instances and decodes I_cfg_wr/I_cfg_ch into per-channel load strobes.

Test Plan:
- Reset, then write ch0 num=10 den=1 -> first toggle 5 cycles after the config edge. Period exactly 10 cycles, 50% duty. One O_clk_en pulse per 10 cycles.
- ch1 num=3 den=1 -> toggles at cycles 2,3,5,6,8,9... after config. Average period 3.000 cycles over 3000 cycles. acc never reaches 3.
- ch2 num=125000 den=2048 -> over 125000 cycles, exactly 2048 O_clk_en pulses. Each half-period is 30 or 31 cycles.
- Config errors:
  - den=0 -> O_cfg_err=1, output stays 0.
  - num=4 den=3 -> O_cfg_err=1.
  - Rewrite num=4 den=2 -> err clears, toggles every cycle.
- Stop/resume: assert I_gen_stop[0] for 7 cycles mid-high phase -> level and acc frozen, no O_clk_en pulses. After release, the toggle sequence is identical to an unstopped reference shifted by 7 cycles.
- Independence and restart:
  - Rewrite ch0 mid-phase while ch1..3 run -> ch0 drops to 0 next cycle; ch1..3 are cycle-identical to a run without the write.
  - I_rst mid-run -> all outputs 0 the following cycle.
